cuckoo_match_collector: RTL and testbench

- Sits directly downstream of the length-12 cuckoo lookup engine.
- Consumes the engine's case and nocase compare_out/suffix results and re-aligns them with the byte offset and end-of-packet tag that were presented at the engine input, using a fixed-latency tag delay line.
- Packs every aligned cycle with a hit, or with end-of-packet, into one record in a small FIFO, drained over a valid/ready interface by the rule-report logic.
- Raises almost_full so the upstream byte feeder can drop the engine's enable before the FIFO overflows.

---
 rtl/cuckoo_match_collector.sv | 161 ++++++++++++++++
 tb/tb_cuckoo_match_collector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cuckoo_match_collector.sv
// Re-aligns cuckoo engine compare results with their byte tags and queues hit/eop records.
// Optional statistics counters are built only when CUCKOO_COLLECT_STATS_EN is defined.
module cuckoo_match_collector #(
  parameter int LATENCY    = 4,
  parameter int OFF_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = LATENCY + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [OFF_W-1:0] byte_offset,
  input  logic             eop,
  input  logic [1:0]       compare_out,
  input  logic [1:0]       suffix,
  input  logic [1:0]       compare_out_nocase,
  input  logic [1:0]       suffix_nocase,
  output logic             match_valid,
  input  logic             match_ready,
  output logic [OFF_W+8:0] match_data,
  output logic             almost_full,
  output logic             overflow,
  output logic [31:0]      total_hits,
  output logic [15:0]      drop_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = OFF_W + 9;

  typedef struct packed {
    logic             v;
    logic             eop;
    logic [OFF_W-1:0] off;
  } tag_t;

  // ---------------------------------------------------------------------------
  // Tag delay line: the tag leaving the last stage belongs to this cycle's
  // compare results.
  // ---------------------------------------------------------------------------
  tag_t tag_q [LATENCY];
  tag_t tag_in;
  tag_t tag_al;

  always_comb begin
    tag_in.v   = enable;
    tag_in.eop = eop & enable;
    tag_in.off = byte_offset;
  end

  assign tag_al = tag_q[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Stale engine results (v=0) never produce a record.
  logic [3:0]       hit_vec;
  logic             push_req;
  logic [REC_W-1:0] rec;

  assign hit_vec  = {compare_out_nocase, compare_out};
  assign push_req = tag_al.v & ((|hit_vec) | tag_al.eop);
  assign rec      = {tag_al.eop, hit_vec, suffix_nocase, suffix, tag_al.off};

  // ---------------------------------------------------------------------------
  // Record FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             af_q, af_d;
  logic             ovf_q, ovf_d;
  logic             full, pop, push_acc, drop;

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    pop      = (cnt_q != '0) & match_ready;
    full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    push_acc = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d    = cnt_q + CNT_W'(push_acc) - CNT_W'(pop);
    af_d     = (CNT_W'(FIFO_DEPTH) - cnt_d) <= CNT_W'(AF_MARGIN);
    ovf_d    = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the empty-gated read
  // below keeps its power-up contents from ever reaching match_data.
  logic [REC_W-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= rec;
  end

  assign match_valid = (cnt_q != '0);
  assign match_data  = match_valid ? mem_q[rd_ptr_q] : '0;
  assign almost_full = af_q;
  assign overflow    = ovf_q;

  // ---------------------------------------------------------------------------
  // Optional saturating statistics
  // ---------------------------------------------------------------------------
`ifdef CUCKOO_COLLECT_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [15:0] drops_q, drops_d;
  logic [2:0]  hit_pop;
  logic [32:0] hit_sum;

  always_comb begin
    hit_pop = 3'(hit_vec[0]) + 3'(hit_vec[1]) + 3'(hit_vec[2]) + 3'(hit_vec[3]);
    hit_sum = {1'b0, hits_q} + 33'(hit_pop);
    hits_d  = hits_q;
    drops_d = drops_q;
    if (push_acc)                  hits_d  = hit_sum[32] ? '1 : hit_sum[31:0];
    if (drop && (drops_q != '1))   drops_d = drops_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q  <= '0;
      drops_q <= '0;
    end else begin
      hits_q  <= hits_d;
      drops_q <= drops_d;
    end
  end

  assign total_hits = hits_q;
  assign drop_cnt   = drops_q;
`else
  assign total_hits = '0;
  assign drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_cuckoo_match_collector.sv
// Directed bench for cuckoo_match_collector: a queue-based model checked every cycle,
// plus hand-computed record values pinned at key points.
module tb_cuckoo_match_collector;

  localparam int LAT   = 4;
  localparam int OFF_W = 16;
  localparam int DEPTH = 16;
  localparam int AFM   = LAT + 1;
  localparam int REC_W = OFF_W + 9;
`ifdef CUCKOO_COLLECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [OFF_W-1:0] byte_offset;
  logic             eop;
  logic [1:0]       compare_out, suffix, compare_out_nocase, suffix_nocase;
  logic             match_valid, match_ready;
  logic [REC_W-1:0] match_data;
  logic             almost_full, overflow;
  logic [31:0]      total_hits;
  logic [15:0]      drop_cnt;

  always #5 clk = ~clk;

  cuckoo_match_collector #(
    .LATENCY(LAT), .OFF_W(OFF_W), .FIFO_DEPTH(DEPTH), .AF_MARGIN(AFM)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .byte_offset(byte_offset), .eop(eop),
    .compare_out(compare_out), .suffix(suffix),
    .compare_out_nocase(compare_out_nocase), .suffix_nocase(suffix_nocase),
    .match_valid(match_valid), .match_ready(match_ready), .match_data(match_data),
    .almost_full(almost_full), .overflow(overflow),
    .total_hits(total_hits), .drop_cnt(drop_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: enables are remembered with their cycle stamp; the one stamped
  // LAT cycles ago meets the current compare inputs.
  // ---------------------------------------------------------------------------
  typedef struct {
    int               stamp;
    logic             eop;
    logic [OFF_W-1:0] off;
  } ev_t;

  ev_t              ev_q[$];
  logic [REC_W-1:0] m_fifo[$];
  bit               m_ovf, m_af;
  longint           m_hits;
  int               m_drops;
  int               cyc = 0;

  always @(posedge clk) begin : model
    bit               av, aeop;
    logic [OFF_W-1:0] aoff;
    logic [3:0]       hits;
    if (rst) begin
      ev_q.delete();
      m_fifo.delete();
      m_ovf   = 1'b0;
      m_af    = 1'b0;
      m_hits  = 0;
      m_drops = 0;
    end else begin
      av   = 1'b0;
      aeop = 1'b0;
      aoff = '0;
      if (ev_q.size() > 0 && ev_q[0].stamp == cyc - LAT) begin
        av   = 1'b1;
        aeop = ev_q[0].eop;
        aoff = ev_q[0].off;
        void'(ev_q.pop_front());
      end
      hits = {compare_out_nocase, compare_out};
      if (m_fifo.size() > 0 && match_ready) void'(m_fifo.pop_front());
      if (av && (hits != 4'd0 || aeop)) begin
        if (m_fifo.size() < DEPTH) begin
          m_fifo.push_back({aeop, hits, suffix_nocase, suffix, aoff});
          m_hits += $countones(hits);
          if (m_hits > 64'hFFFF_FFFF) m_hits = 64'hFFFF_FFFF;
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      m_af = (DEPTH - m_fifo.size()) <= AFM;
      if (enable) ev_q.push_back('{cyc, eop, byte_offset});
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("match_valid", match_valid, m_fifo.size() > 0);
      check("match_data", match_data, (m_fifo.size() > 0) ? m_fifo[0] : '0);
      check("almost_full", almost_full, m_af);
      check("overflow", overflow, m_ovf);
      check("total_hits", total_hits, STATS ? m_hits[31:0] : 32'd0);
      check("drop_cnt", drop_cnt, STATS ? 16'(m_drops) : 16'd0);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; byte_offset = '0; eop = 1'b0;
    compare_out = '0; suffix = '0; compare_out_nocase = '0; suffix_nocase = '0;
    match_ready = 1'b0;
    step(2);
    chk_en = 1'b1;
    check("rst_valid", match_valid, 1'b0);
    check("rst_data", match_data, 25'h0);
    check("rst_af", almost_full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_hits", total_hits, 32'd0);
    check("rst_drops", drop_cnt, 16'd0);
    rst = 1'b0;

    // Single case hit, four cycles after its enable.
    enable = 1'b1; byte_offset = 16'h0010; step();
    enable = 1'b0; step(3);
    check("t1_not_early", match_valid, 1'b0);
    compare_out = 2'b01; step();
    compare_out = 2'b00;
    check("t1_valid", match_valid, 1'b1);
    check("t1_data", match_data, 25'h0100010);
    match_ready = 1'b1; step(); match_ready = 1'b0;
    check("t1_popped", match_valid, 1'b0);

    // Stale results while enable is low are ignored.
    compare_out = 2'b11; step(3); compare_out = 2'b00;
    check("t2_no_push", match_valid, 1'b0);

    // Mixed case/nocase hits on an eop position.
    enable = 1'b1; eop = 1'b1; byte_offset = 16'h0042; step();
    enable = 1'b0; eop = 1'b0; step(3);
    compare_out = 2'b10; compare_out_nocase = 2'b01; suffix = 2'b10; suffix_nocase = 2'b01;
    step();
    compare_out = '0; compare_out_nocase = '0; suffix = '0; suffix_nocase = '0;
    check("t3_data", match_data, 25'h1660042);
    check("t3_hits", total_hits, STATS ? 32'd3 : 32'd0);
    match_ready = 1'b1; step(); match_ready = 1'b0;

    // eop without any hit still produces a record.
    enable = 1'b1; eop = 1'b1; byte_offset = 16'h0050; step();
    enable = 1'b0; eop = 1'b0; step(4);
    check("t3b_data", match_data, 25'h1000050);
    match_ready = 1'b1; step(); match_ready = 1'b0;

    // Fill with no consumer: 16 accepted, 17th dropped.
    compare_out = 2'b01;
    for (int i = 0; i < 21; i++) begin
      enable = (i < 17);
      byte_offset = 16'h0100 + 16'(i);
      step();
      if (i == 13) check("t4_af_at_10", almost_full, 1'b0);
      if (i == 14) check("t4_af_at_11", almost_full, 1'b1);
    end
    enable = 1'b0; compare_out = 2'b00;
    check("t4_ovf", overflow, 1'b1);
    check("t4_drops", drop_cnt, STATS ? 16'd1 : 16'd0);
    check("t4_head", match_data, 25'h0100100);

    // Full FIFO, pop and push in the same cycle.
    enable = 1'b1; byte_offset = 16'h0200; step();
    enable = 1'b0; step(3);
    compare_out = 2'b01; match_ready = 1'b1; step();
    compare_out = 2'b00; match_ready = 1'b0;
    check("t5_drops", drop_cnt, STATS ? 16'd1 : 16'd0);
    check("t5_af", almost_full, 1'b1);
    check("t5_head", match_data, 25'h0100101);
    match_ready = 1'b1; step(15);
    check("t5_tail", match_data, 25'h0100200);
    step(); match_ready = 1'b0;
    check("t5_empty", match_valid, 1'b0);

    // Reset with 5 queued records and 3 tags in flight.
    compare_out = 2'b01;
    for (int i = 0; i < 9; i++) begin
      enable = (i < 8);
      byte_offset = 16'h0300 + 16'(i);
      step();
    end
    enable = 1'b0;
    check("t6_head", match_data, 25'h0100300);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_rst_valid", match_valid, 1'b0);
    check("t6_rst_ovf", overflow, 1'b0);
    match_ready = 1'b1; step(8);
    check("t6_no_stale", match_valid, 1'b0);
    compare_out = 2'b00; match_ready = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
